// File: rtl/dmem_pkg.sv
// Shared types for the data memory controller: access-size encodings,
// controller state encoding and the wait-state counter width.
package dmem_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
// Store side merges right-justified write data into the addressed lanes of
// the old word; load side extracts those lanes and sign/zero extends them.
// The lane input is expected already forced to the natural alignment of the
// access size (half: lane[0]=0, word: lane=0).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  size_e       i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    output logic [31:0] o_new_word,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    assign w_shifted = i_word >> {i_lane, 3'b000};

    // Store merge: overwrite only the lanes touched by the access size.
    always_comb begin
        o_new_word = i_word;
        case (i_size)
            SIZE_B:  o_new_word[{i_lane, 3'b000} +: 8]    = i_wdata[7:0];
            SIZE_H:  o_new_word[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            SIZE_W:  o_new_word = i_wdata;
            default: o_new_word = i_word;
        endcase
    end

    // Load extract: pick the lanes, then extend; word loads ignore i_unsigned.
    always_comb begin
        o_rdata = '0;
        case (i_size)
            SIZE_B:  o_rdata = {{24{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            SIZE_H:  o_rdata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            SIZE_W:  o_rdata = i_word;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked byte-addressable data memory with programmable wait states.
// Optional build macro: DMEM_ALIGN_CHECK_EN -- when defined, misaligned half
// and word accesses are rejected with resp_err; otherwise the low address
// bits are forced to the natural alignment and the access proceeds.
// The memory array has no reset so its contents survive a controller reset.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_e            r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_cnt, w_cnt_nxt;
    logic              w_commit;
    logic              w_accept;

    logic        r_write;
    logic [31:0] r_addr;
    size_e       r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH];

    // With zero wait states the commit edge is the acceptance edge, so the
    // request is taken straight from the inputs while still in IDLE.
    logic        w_cur_write;
    logic [31:0] w_cur_addr;
    size_e       w_cur_size;
    logic        w_cur_unsigned;
    logic [31:0] w_cur_wdata;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_oor;
    logic          w_misalign;
    logic          w_err;
    logic [31:0]   w_new_word;
    logic [31:0]   w_load_data;

    assign w_accept    = i_req_valid && (r_state == IDLE);
    assign o_req_ready = (r_state == IDLE);
    assign o_resp_valid = (r_state == RESP);
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

    assign w_cur_write    = (r_state == IDLE) ? i_req_write         : r_write;
    assign w_cur_addr     = (r_state == IDLE) ? i_req_addr          : r_addr;
    assign w_cur_size     = (r_state == IDLE) ? size_e'(i_req_size) : r_size;
    assign w_cur_unsigned = (r_state == IDLE) ? i_req_unsigned      : r_unsigned;
    assign w_cur_wdata    = (r_state == IDLE) ? i_req_wdata         : r_wdata;

    assign w_idx = w_cur_addr[AW+1:2];
    assign w_oor = (w_cur_addr[31:AW+2] != '0);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = ((w_cur_size == SIZE_H) && w_cur_addr[0]) ||
                        ((w_cur_size == SIZE_W) && (w_cur_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_oor || (w_cur_size == SIZE_RSV) || w_misalign;

    // Force the lane to the natural alignment of the access size.
    always_comb begin
        w_lane = w_cur_addr[1:0];
        case (w_cur_size)
            SIZE_H:  w_lane = {w_cur_addr[1], 1'b0};
            SIZE_W:  w_lane = 2'b00;
            default: w_lane = w_cur_addr[1:0];
        endcase
    end

    dmem_lane_align u_lane_align (
        .i_word     (r_mem[w_idx]),
        .i_wdata    (w_cur_wdata),
        .i_size     (w_cur_size),
        .i_lane     (w_lane),
        .i_unsigned (w_cur_unsigned),
        .o_new_word (w_new_word),
        .o_rdata    (w_load_data)
    );

    // State and wait counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; w_commit marks the edge that enters RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end else begin
                        w_state_nxt = RESP;
                        w_commit    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the request on acceptance.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_size     <= SIZE_B;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_write    <= i_req_write;
            r_addr     <= i_req_addr;
            r_size     <= size_e'(i_req_size);
            r_unsigned <= i_req_unsigned;
            r_wdata    <= i_req_wdata;
        end
    end

    // Response data and error, sampled on the commit edge and held after.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_cur_write) ? '0 : w_load_data;
        end
    end

    // Memory write on commit; never while reset is held.
    always_ff @(posedge i_clk) begin
        if (w_commit && w_cur_write && !w_err && !i_reset) begin
            r_mem[w_idx] <= w_new_word;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one instance with no wait states and one with
// three, each checked every cycle against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst          [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_write    [2];
    logic [31:0] req_addr     [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(g == 0 ? 0 : 3)) dut (
            .i_clk          (clk),
            .i_reset        (rst[g]),
            .i_req_valid    (req_valid[g]),
            .o_req_ready    (req_ready[g]),
            .i_req_write    (req_write[g]),
            .i_req_addr     (req_addr[g]),
            .i_req_size     (req_size[g]),
            .i_req_unsigned (req_unsigned[g]),
            .i_req_wdata    (req_wdata[g]),
            .o_resp_valid   (resp_valid[g]),
            .o_resp_rdata   (resp_rdata[g]),
            .o_resp_err     (resp_err[g])
        );
    end

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        bit          we;
        int          baddr;
        int          nb;
        logic [31:0] wd;
    } exp_t;

    exp_t        pend       [2];
    bit          has_pend   [2];
    logic [31:0] last_rdata [2];
    logic        last_err   [2];
    logic [7:0]  mb         [2][DEPTH*4];
    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    function automatic int wc(int u);
        return (u == 0) ? 0 : 3;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: computes the response at acceptance; a store is held
    // pending and applied to the byte array only when its response appears.
    function automatic void model_req(int u, bit w, logic [31:0] a, logic [1:0] s,
                                      bit un, logic [31:0] d);
        exp_t   e;
        int     nb;
        int     base;
        longint val;
        bit     err;
        nb  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        err = (a >= 32'(DEPTH*4)) || (s == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((s != 2'b11) && ((int'(a[1:0]) % nb) != 0)) err = 1'b1;
`endif
        e.due   = cyc + 1 + wc(u);
        e.err   = err;
        e.we    = 1'b0;
        e.rdata = '0;
        e.baddr = 0;
        e.nb    = nb;
        e.wd    = d;
        if (!err) begin
            base = int'(a[15:0]) - (int'(a[1:0]) % nb);
            if (w) begin
                e.we    = 1'b1;
                e.baddr = base;
            end else begin
                val = 0;
                for (int i = 0; i < nb; i++)
                    val = val + (longint'(mb[u][base+i]) << (8*i));
                if (!un && nb < 4 && val[8*nb-1])
                    val = val - (longint'(1) << (8*nb));
                e.rdata = val[31:0];
            end
        end
        pend[u]     = e;
        has_pend[u] = 1'b1;
    endfunction

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            bit ev;
            ev = has_pend[u] && (pend[u].due == cyc);
            check($sformatf("u%0d req_ready", u), 32'(req_ready[u]), 32'(!has_pend[u]));
            check($sformatf("u%0d resp_valid", u), 32'(resp_valid[u]), 32'(ev));
            if (ev) begin
                if (resp_valid[u]) begin
                    check($sformatf("u%0d resp_rdata", u), resp_rdata[u], pend[u].rdata);
                    check($sformatf("u%0d resp_err", u), 32'(resp_err[u]), 32'(pend[u].err));
                end
                if (pend[u].we)
                    for (int i = 0; i < pend[u].nb; i++)
                        mb[u][pend[u].baddr+i] = 8'(pend[u].wd >> (8*i));
                last_rdata[u] = resp_rdata[u];
                last_err[u]   = resp_err[u];
                has_pend[u]   = 1'b0;
            end
        end
    end

    // Present a request and hold it until accepted; returns just after the
    // negedge following the acceptance edge with req_valid dropped.
    task automatic issue(int u, bit w, logic [31:0] a, logic [1:0] s, bit un,
                         logic [31:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk); #1;
        req_valid[u]    = 1'b1;
        req_write[u]    = w;
        req_addr[u]     = a;
        req_size[u]     = s;
        req_unsigned[u] = un;
        req_wdata[u]    = d;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (req_ready[u]) begin
                ok = 1'b1;
                model_req(u, w, a, s, un, d);
            end else begin
                @(negedge clk); #1;
            end
        end
        if (ok) begin
            @(negedge clk); #1;
        end
        req_valid[u] = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL u%0d accept: req_ready never high, want high within 40 cycles", u);
        end
    endtask

    task automatic wait_idle(int u);
        int k;
        k = 0;
        while (has_pend[u] && k < 40) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (has_pend[u]) begin
            fails++;
            $display("FAIL u%0d response timeout: no resp_valid, want one", u);
            has_pend[u] = 1'b0;
        end
    endtask

    task automatic access(int u, bit w, logic [31:0] a, logic [1:0] s, bit un,
                          logic [31:0] d);
        issue(u, w, a, s, un, d);
        wait_idle(u);
    endtask

    task automatic fill(int u);
        for (int i = 0; i < DEPTH; i++)
            access(u, 1'b1, 32'(i*4), 2'b10, 1'b0, $urandom);
    endtask

    task automatic rand_phase(int u, int n);
        for (int i = 0; i < n; i++) begin
            int          r;
            logic [1:0]  s;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            s = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 9) == 0)
                a = 32'(DEPTH*4) + $urandom_range(0, 8191);
            else
                a = $urandom_range(0, DEPTH*4 - 1);
            access(u, 1'(($urandom_range(0, 1))), a, s, 1'(($urandom_range(0, 1))), $urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        for (int u = 0; u < 2; u++) begin
            rst[u]          = 1'b1;
            req_valid[u]    = 1'b0;
            req_write[u]    = 1'b0;
            req_addr[u]     = '0;
            req_size[u]     = '0;
            req_unsigned[u] = 1'b0;
            req_wdata[u]    = '0;
            has_pend[u]     = 1'b0;
            last_rdata[u]   = '0;
            last_err[u]     = 1'b0;
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d reset req_ready", u), 32'(req_ready[u]), 32'd1);
            check($sformatf("u%0d reset resp_valid", u), 32'(resp_valid[u]), 32'd0);
            check($sformatf("u%0d reset resp_rdata", u), resp_rdata[u], 32'h0);
            check($sformatf("u%0d reset resp_err", u), 32'(resp_err[u]), 32'd0);
        end
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        fork
            fill(0);
            fill(1);
        join

        // Directed sequence, zero wait states.
        access(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        check("sw 0x10 err", 32'(last_err[0]), 32'd0);
        check("sw 0x10 rdata", last_rdata[0], 32'h0);
        access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        check("lw 0x10", last_rdata[0], 32'hDEADBEEF);
        access(0, 1'b1, 32'h11, 2'b00, 1'b0, 32'h12345680);
        access(0, 1'b0, 32'h11, 2'b00, 1'b0, 32'h0);
        check("lb 0x11", last_rdata[0], 32'hFFFFFF80);
        access(0, 1'b0, 32'h11, 2'b00, 1'b1, 32'h0);
        check("lbu 0x11", last_rdata[0], 32'h00000080);
        access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        check("lw 0x10 merged", last_rdata[0], 32'hDEAD80EF);
        access(0, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0);
        check("lhu 0x12", last_rdata[0], 32'h0000DEAD);
        access(0, 1'b0, 32'h13, 2'b10, 1'b0, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("lw 0x13 err", 32'(last_err[0]), 32'd1);
        check("lw 0x13 rdata", last_rdata[0], 32'h0);
`else
        check("lw 0x13 err", 32'(last_err[0]), 32'd0);
        check("lw 0x13 rdata", last_rdata[0], 32'hDEAD80EF);
`endif
        access(0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h01234567);
        access(0, 1'b1, 32'h400, 2'b10, 1'b0, 32'hFFFFFFFF);
        check("sw 0x400 err", 32'(last_err[0]), 32'd1);
        check("sw 0x400 rdata", last_rdata[0], 32'h0);
        access(0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
        check("lw 0x0 after oor", last_rdata[0], 32'h01234567);
        access(0, 1'b0, 32'h10, 2'b11, 1'b0, 32'h0);
        check("rsv size err", 32'(last_err[0]), 32'd1);
        check("rsv size rdata", last_rdata[0], 32'h0);

        // Three wait states: reset during WAIT drops the pending store.
        access(1, 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D);
        issue(1, 1'b1, 32'h20, 2'b10, 1'b0, 32'h12345678);
        rst[1]      = 1'b1;
        has_pend[1] = 1'b0;
        @(negedge clk);
        check("u1 mid-reset req_ready", 32'(req_ready[1]), 32'd1);
        check("u1 mid-reset resp_valid", 32'(resp_valid[1]), 32'd0);
        #1;
        rst[1] = 1'b0;
        repeat (6) @(negedge clk);
        access(1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        check("u1 lw 0x20 after reset", last_rdata[1], 32'hCAFEF00D);

        // Latency and ignored pulses while busy.
        issue(1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        n    = 0;
        seen = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (resp_valid[1] && !seen) begin
                seen = 1'b1;
                n    = k;
            end
            #1;
            req_write[1] = 1'b1;
            req_addr[1]  = 32'h20;
            req_size[1]  = 2'b10;
            req_wdata[1] = 32'hBAD0BAD0;
            req_valid[1] = (k == 1 || k == 3);
        end
        req_valid[1] = 1'b0;
        check("u1 resp cycle after accept", 32'(n), 32'd3);
        wait_idle(1);
        repeat (3) @(negedge clk);
        access(1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        check("u1 lw 0x20 after pulses", last_rdata[1], 32'hCAFEF00D);

        fork
            rand_phase(0, 400);
            rand_phase(1, 250);
        join

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
